// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - SRAM command arbiter: buffered writes, read priority with bounded bursts, read return pipeline
module sram_arbiter #(
  parameter int READ_LATENCY   = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int MAX_READ_BURST = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [19:0] wr_addr,
  input  logic [16:0] wr_data,
  input  logic        rd_valid,
  output logic        rd_ready,
  input  logic [19:0] rd_addr,
  output logic        rd_data_valid,
  output logic [16:0] rd_data,
  output logic [19:0] sram_addr,
  output logic        sram_write_enable,
  output logic [16:0] sram_data_in,
  input  logic [16:0] sram_data_out
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(MAX_READ_BURST + 1);

  logic [19:0]             fifo_addr [FIFO_DEPTH];
  logic [16:0]             fifo_data [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [CW-1:0]           count;
  logic [BW-1:0]           burst_cnt;
  logic [READ_LATENCY-1:0] rd_pipe;

  logic fifo_full;
  logic fifo_empty;
  logic forced_wr;
  logic rd_issue;
  logic wr_issue;
  logic push;

  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  // A full FIFO or an exhausted read burst starves reads for one cycle.
  assign forced_wr  = fifo_full || (!fifo_empty && burst_cnt == BW'(MAX_READ_BURST));
  assign rd_ready   = !rst && !forced_wr;
  assign wr_ready   = !rst && !fifo_full;
  assign rd_issue   = rd_valid && rd_ready;
  assign wr_issue   = !rst && !fifo_empty && !rd_issue;
  assign push       = wr_valid && wr_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= wr_addr;
      fifo_data[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      count             <= '0;
      burst_cnt         <= '0;
      rd_pipe           <= '0;
      rd_data_valid     <= 1'b0;
      rd_data           <= '0;
      sram_addr         <= '0;
      sram_write_enable <= 1'b0;
      sram_data_in      <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (wr_issue) rd_ptr <= rd_ptr + PW'(1);
      case ({push, wr_issue})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (wr_issue) begin
        sram_write_enable <= 1'b1;
        sram_addr         <= fifo_addr[rd_ptr];
        sram_data_in      <= fifo_data[rd_ptr];
      end else if (rd_issue) begin
        sram_write_enable <= 1'b0;
        sram_addr         <= rd_addr;
      end else begin
        sram_write_enable <= 1'b0;
      end

      // Burst length only matters while a write is waiting behind the reads.
      if (wr_issue || fifo_empty)
        burst_cnt <= '0;
      else if (rd_issue && burst_cnt != BW'(MAX_READ_BURST))
        burst_cnt <= burst_cnt + BW'(1);

      rd_pipe       <= (rd_pipe << 1) | READ_LATENCY'(rd_issue);
      rd_data_valid <= rd_pipe[READ_LATENCY-1];
      if (rd_pipe[READ_LATENCY-1]) rd_data <= sram_data_out;
    end
  end

endmodule
